// File: rtl/imm_gen_stage_pkg.sv
// imm_gen_stage_pkg: immediate format encoding and RV opcode constants
package imm_gen_stage_pkg;
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
endpackage

// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: fetch-side and decode-side valid/ready streams plus flush
interface imm_gen_stage_if import imm_gen_stage_pkg::*; #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    imm_type_e       out_imm_type;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;
    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type, out_target, out_illegal
    );
    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type, out_target, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational RV opcode decode to sign-extended immediate and format
module imm_decode import imm_gen_stage_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int CSR_EN = 1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);
    localparam bit IS64 = (XLEN == 64);
    logic [31:0] imm32;
    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_type = IMM_I;
            OP_IMM32: begin
                imm_type = IS64 ? IMM_I : IMM_NONE;
                illegal  = !IS64;
            end
            OP_STORE:        imm_type = IMM_S;
            OP_BRANCH:       imm_type = IMM_B;
            OP_LUI, OP_AUIPC: imm_type = IMM_U;
            OP_JAL:          imm_type = IMM_J;
            OP_SYSTEM:       imm_type = (CSR_EN != 0 && inst[14]) ? IMM_Z : IMM_I;
            OP_REG, OP_FENCE: imm_type = IMM_NONE;
            OP_REG32:        illegal = !IS64;
            default:         illegal = 1'b1;
        endcase
    end
    // every format fits a signed 32-bit value, so widen once at the end
    assign imm32 = (imm_type == IMM_I) ? {{20{inst[31]}}, inst[31:20]} :
                   (imm_type == IMM_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                   (imm_type == IMM_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                   (imm_type == IMM_U) ? {inst[31:12], 12'b0} :
                   (imm_type == IMM_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                   (imm_type == IMM_Z) ? {27'b0, inst[19:15]} : 32'b0;
    assign imm = XLEN'(signed'(imm32));
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generation with branch target and optional skid buffer
module imm_gen_stage import imm_gen_stage_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1,
    parameter int CSR_EN  = 1
) (
    input logic            clk,
    input logic            rst_n,
    imm_gen_stage_if.slave bus
);
    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        imm_type_e       imm_type;
        logic            illegal;
    } entry_t;
    entry_t          new_e, main_q, skid_q;
    logic            main_v, skid_v, main_free, in_fire;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_ill;
    imm_decode #(.XLEN(XLEN), .CSR_EN(CSR_EN)) u_dec (
        .inst     (bus.in_inst),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_ill)
    );
    assign new_e = '{inst: bus.in_inst, pc: bus.in_pc, imm: dec_imm, target: bus.in_pc + dec_imm,
                     imm_type: dec_type, illegal: dec_ill};
    assign main_free    = !main_v || bus.out_ready;
    assign bus.in_ready = (SKID_EN != 0) ? !skid_v : main_free;
    assign in_fire      = bus.in_valid && bus.in_ready;
    // skid only fills while main is stalled; in_ready = !skid_v keeps it single-entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (main_free) begin
            main_v <= skid_v || in_fire;
            main_q <= skid_v ? skid_q : new_e;
            skid_v <= 1'b0;
        end else if (in_fire) begin
            skid_v <= 1'b1;
            skid_q <= new_e;
        end
    end
    assign bus.out_valid    = main_v;
    assign bus.out_inst     = main_q.inst;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_imm      = main_q.imm;
    assign bus.out_imm_type = main_q.imm_type;
    assign bus.out_target   = main_q.target;
    assign bus.out_illegal  = main_q.illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed vectors and handshake sequences over three stage configurations
module tb_imm_gen_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    imm_gen_stage_if #(.XLEN(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64)) b64 ();
    imm_gen_stage_if #(.XLEN(32)) b0 ();
    imm_gen_stage #(.XLEN(32), .SKID_EN(1), .CSR_EN(1)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_gen_stage #(.XLEN(64), .SKID_EN(1), .CSR_EN(1)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
    imm_gen_stage #(.XLEN(32), .SKID_EN(0), .CSR_EN(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] i32;
        logic [2:0]  t32;
        logic        l32;
        logic [63:0] i64;
        logic [2:0]  t64;
        logic        l64;
        logic [31:0] i0;
        logic [2:0]  t0;
    } vec_t;
    localparam int NV = 16;
    vec_t        vt [NV];
    logic [31:0] sinst [6];
    logic [31:0] t32;
    logic [63:0] t64;
    int s32, s64, s0, r32, r64, r0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        b32.in_valid = v; b32.in_inst = inst; b32.in_pc = pc;
        b64.in_valid = v; b64.in_inst = inst; b64.in_pc = {32'h0, pc};
        b0.in_valid  = v; b0.in_inst  = inst; b0.in_pc  = pc;
    endtask
    task automatic ctl(input logic rdy, input logic fl);
        b32.out_ready = rdy; b64.out_ready = rdy; b0.out_ready = rdy;
        b32.flush = fl; b64.flush = fl; b0.flush = fl;
    endtask
    task automatic idle_chk(input string tag, input logic data_zero);
        chk({tag, ".valid32"}, b32.out_valid, 0);
        chk({tag, ".valid64"}, b64.out_valid, 0);
        chk({tag, ".valid0"}, b0.out_valid, 0);
        chk({tag, ".ready32"}, b32.in_ready, 1);
        chk({tag, ".ready64"}, b64.in_ready, 1);
        chk({tag, ".ready0"}, b0.in_ready, 1);
        if (data_zero) begin
            chk({tag, ".data32"}, {b32.out_inst, b32.out_pc, b32.out_imm, b32.out_target} == 0, 1);
            chk({tag, ".data64"}, {b64.out_inst, b64.out_pc, b64.out_imm, b64.out_target} == 0, 1);
            chk({tag, ".type32"}, {b32.out_imm_type, b32.out_illegal}, 0);
            chk({tag, ".inst0"}, b0.out_inst, 0);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        vt[0]  = '{32'hFFF00093, 32'h100,      32'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1};
        vt[1]  = '{32'hFE000EE3, 32'h100,      32'hFFFFFFFC, 3, 0, 64'hFFFFFFFFFFFFFFFC, 3, 0, 32'hFFFFFFFC, 3};
        vt[2]  = '{32'h800000B7, 32'h100,      32'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0, 32'h80000000, 4};
        vt[3]  = '{32'h0000501B, 32'h100,      32'h0,        0, 1, 64'h0,                1, 0, 32'h0,        0};
        vt[4]  = '{32'h0007D073, 32'h100,      32'hF,        6, 0, 64'hF,                6, 0, 32'h0,        1};
        vt[5]  = '{32'hFE20AC23, 32'h200,      32'hFFFFFFF8, 2, 0, 64'hFFFFFFFFFFFFFFF8, 2, 0, 32'hFFFFFFF8, 2};
        vt[6]  = '{32'h0010006F, 32'h100,      32'h800,      5, 0, 64'h800,              5, 0, 32'h800,      5};
        vt[7]  = '{32'hFFDFF0EF, 32'h0,        32'hFFFFFFFC, 5, 0, 64'hFFFFFFFFFFFFFFFC, 5, 0, 32'hFFFFFFFC, 5};
        vt[8]  = '{32'h12345297, 32'h1000,     32'h12345000, 4, 0, 64'h12345000,         4, 0, 32'h12345000, 4};
        vt[9]  = '{32'h003100B3, 32'h104,      32'h0,        0, 0, 64'h0,                0, 0, 32'h0,        0};
        vt[10] = '{32'h003100BB, 32'h108,      32'h0,        0, 1, 64'h0,                0, 0, 32'h0,        0};
        vt[11] = '{32'h0FF0000F, 32'h10C,      32'h0,        0, 0, 64'h0,                0, 0, 32'h0,        0};
        vt[12] = '{32'h00000000, 32'h110,      32'h0,        0, 1, 64'h0,                0, 1, 32'h0,        0};
        vt[13] = '{32'h7FF12083, 32'hFFFFF900, 32'h7FF,      1, 0, 64'h7FF,              1, 0, 32'h7FF,      1};
        vt[14] = '{32'hF11020F3, 32'h200,      32'hFFFFFF11, 1, 0, 64'hFFFFFFFFFFFFFF11, 1, 0, 32'hFFFFFF11, 1};
        vt[15] = '{32'hFFFFFFFF, 32'h114,      32'h0,        0, 1, 64'h0,                0, 1, 32'h0,        0};
        for (int k = 0; k < 5; k++) sinst[k] = 32'h00000093 | (32'(k + 1) << 20);
        sinst[5] = 32'hDEADBEEF;
        drive(0, 0, 0);
        ctl(1, 0);
        step();
        step();
        idle_chk("reset", 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        idle_chk("post_reset", 0);
        for (int i = 0; i < NV; i++) begin
            drive(1, vt[i].inst, vt[i].pc);
            step();
            t32 = vt[i].pc + vt[i].i32;
            t64 = {32'h0, vt[i].pc} + vt[i].i64;
            chk($sformatf("v%0d.valid32", i), b32.out_valid, 1);
            chk($sformatf("v%0d.inst32", i), b32.out_inst, vt[i].inst);
            chk($sformatf("v%0d.pc32", i), b32.out_pc, vt[i].pc);
            chk($sformatf("v%0d.imm32", i), b32.out_imm, vt[i].i32);
            chk($sformatf("v%0d.type32", i), b32.out_imm_type, vt[i].t32);
            chk($sformatf("v%0d.ill32", i), b32.out_illegal, vt[i].l32);
            chk($sformatf("v%0d.tgt32", i), b32.out_target, t32);
            chk($sformatf("v%0d.valid64", i), b64.out_valid, 1);
            chk($sformatf("v%0d.imm64", i), b64.out_imm, vt[i].i64);
            chk($sformatf("v%0d.type64", i), b64.out_imm_type, vt[i].t64);
            chk($sformatf("v%0d.ill64", i), b64.out_illegal, vt[i].l64);
            chk($sformatf("v%0d.tgt64", i), b64.out_target, t64);
            chk($sformatf("v%0d.valid0", i), b0.out_valid, 1);
            chk($sformatf("v%0d.imm0", i), b0.out_imm, vt[i].i0);
            chk($sformatf("v%0d.type0", i), b0.out_imm_type, vt[i].t0);
            chk($sformatf("v%0d.ill0", i), b0.out_illegal, vt[i].l32);
        end
        drive(0, 0, 0);
        step();
        idle_chk("drain", 0);
        // backpressure: out_ready low for the first three cycles of a 5-entry stream
        s32 = 0; s64 = 0; s0 = 0; r32 = 0; r64 = 0; r0 = 0;
        for (int c = 0; c < 40; c++) begin
            ctl(c >= 3, 0);
            b32.in_valid = s32 < 5; b32.in_inst = sinst[s32]; b32.in_pc = 32'h800;
            b64.in_valid = s64 < 5; b64.in_inst = sinst[s64]; b64.in_pc = 64'h800;
            b0.in_valid  = s0 < 5;  b0.in_inst  = sinst[s0];  b0.in_pc  = 32'h800;
            @(negedge clk);
            if (c == 1) chk("bp.ready32_c1", b32.in_ready, 1);
            if (c == 2) begin
                chk("bp.ready32_c2", b32.in_ready, 0);
                chk("bp.ready64_c2", b64.in_ready, 0);
                chk("bp.hold32", b32.out_inst, sinst[0]);
                chk("bp.hold0", b0.out_inst, sinst[0]);
            end
            if (b32.out_valid && b32.out_ready) begin
                chk($sformatf("bp.order32_%0d", r32), b32.out_inst, sinst[r32]);
                if (r32 < 5) r32++;
            end
            if (b64.out_valid && b64.out_ready) begin
                chk($sformatf("bp.order64_%0d", r64), b64.out_inst, sinst[r64]);
                if (r64 < 5) r64++;
            end
            if (b0.out_valid && b0.out_ready) begin
                chk($sformatf("bp.order0_%0d", r0), b0.out_inst, sinst[r0]);
                if (r0 < 5) r0++;
            end
            if (b32.in_valid && b32.in_ready) s32++;
            if (b64.in_valid && b64.in_ready) s64++;
            if (b0.in_valid && b0.in_ready) s0++;
            step();
        end
        chk("bp.count32", r32, 5);
        chk("bp.count64", r64, 5);
        chk("bp.count0", r0, 5);
        // flush with main and skid full and a new input offered
        ctl(0, 0);
        drive(1, 32'h00100093, 32'h300);
        step();
        drive(1, 32'h00200093, 32'h304);
        step();
        chk("fl.ready32_full", b32.in_ready, 0);
        chk("fl.ready64_full", b64.in_ready, 0);
        drive(1, 32'h00300093, 32'h308);
        ctl(0, 1);
        step();
        idle_chk("flush", 0);
        ctl(1, 0);
        drive(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("fl.gone32_%0d", k), b32.out_valid, 0);
            chk($sformatf("fl.gone64_%0d", k), b64.out_valid, 0);
            chk($sformatf("fl.gone0_%0d", k), b0.out_valid, 0);
        end
        drive(1, 32'h00500093, 32'h400);
        step();
        chk("fl.next_valid32", b32.out_valid, 1);
        chk("fl.next_inst32", b32.out_inst, 32'h00500093);
        chk("fl.next_tgt32", b32.out_target, 32'h405);
        chk("fl.next_inst64", b64.out_inst, 32'h00500093);
        chk("fl.next_inst0", b0.out_inst, 32'h00500093);
        drive(0, 0, 0);
        step();
        idle_chk("fl.after", 0);
        // asynchronous reset in the middle of a stream
        drive(1, 32'h00700093, 32'h500);
        step();
        chk("ar.valid_before", b32.out_valid, 1);
        drive(1, 32'h00800093, 32'h504);
        #2;
        rst_n = 1'b0;
        #1;
        idle_chk("async_reset", 1);
        step();
        #2;
        rst_n = 1'b1;
        #1;
        idle_chk("ar.release", 0);
        drive(1, 32'h00900093, 32'h600);
        step();
        chk("ar.first_valid32", b32.out_valid, 1);
        chk("ar.first_inst32", b32.out_inst, 32'h00900093);
        chk("ar.first_tgt32", b32.out_target, 32'h609);
        chk("ar.first_tgt64", b64.out_target, 64'h609);
        chk("ar.first_valid0", b0.out_valid, 1);
        drive(0, 0, 0);
        step();
        chk("ar.drain32", b32.out_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
